// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: ALU opcodes and the EX/MEM skid-buffer state encoding.
package mips_pkg;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_ADDU = 3'b101;
  localparam logic [2:0] ALU_MOVN = 3'b111;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_e;

  // Signed ops whose suppressed write (in_wrctr==0) means an overflow occurred.
  function automatic logic is_trap_op(input logic [2:0] op);
    return (op == ALU_ADD) || (op == ALU_SUB);
  endfunction

endpackage

// File: rtl/skid_store2.sv
// Two-entry FIFO data storage for the EX/MEM skid buffer; head is always the oldest entry.
module skid_store2
  import mips_pkg::*;
#(
  parameter int W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  skid_state_e state_i,
  input  logic        push_i,
  input  logic        pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] head_o
);

  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    case (state_i)
      ST_EMPTY: if (push_i) head_d = din_i;
      ST_ONE: begin
        if (push_i && pop_i) head_d = din_i;
        else if (push_i)     tail_d = din_i;
      end
      // Pop from full promotes the second entry in the same edge.
      ST_TWO: if (pop_i) head_d = tail_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  assign head_o = head_q;

endmodule

// File: rtl/exmem_skid.sv
// EX/MEM two-entry skid buffer: handshake control, write gating and sticky overflow trap.
// Optional overflow trap enabled by defining EXMEM_OVF_TRAP_EN.
module exmem_skid
  import mips_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_aluctr,
  input  logic [DW-1:0] in_res,
  input  logic          in_zero,
  input  logic          in_wrctr,
  input  logic          in_regwre,
  input  logic [RW-1:0] in_rd,
  input  logic          in_memrd,
  input  logic          in_memwr,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_res,
  output logic          out_zero,
  output logic [RW-1:0] out_rd,
  output logic          out_regwe,
  output logic          out_memrd,
  output logic          out_memwr,
  output logic          ovf_exc,
  input  logic          ovf_clr
);

  localparam int EW = DW + 1 + RW + 3;

  skid_state_e   state_q, state_d;
  logic          push, pop, trap_cond;
  logic          regwe_st, memwr_st;
  logic [EW-1:0] ent_in, head;

  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign trap_cond = is_trap_op(in_aluctr) & ~in_wrctr;
  assign regwe_st  = in_regwre & in_wrctr & (in_rd != '0);
  assign memwr_st  = in_memwr & ~trap_cond;
  assign ent_in    = {in_res, in_zero, in_rd, regwe_st, in_memrd, memwr_st};

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (push) state_d = ST_ONE;
        ST_ONE: begin
          if (push && !pop)      state_d = ST_TWO;
          else if (pop && !push) state_d = ST_EMPTY;
        end
        ST_TWO:   if (pop) state_d = ST_ONE;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    out_valid = (state_q != ST_EMPTY);
    in_ready  = (state_q != ST_TWO) & ~flush & ~ovf_exc & ~rst;
  end

  skid_store2 #(.W(EW)) u_store (
    .clk    (clk),
    .rst    (rst),
    .state_i(state_q),
    .push_i (push),
    .pop_i  (pop),
    .din_i  (ent_in),
    .head_o (head)
  );

  assign out_res   = head[EW-1 -: DW];
  assign out_zero  = head[RW+3];
  assign out_rd    = head[RW+2 -: RW];
  assign out_regwe = head[2] & out_valid;
  assign out_memrd = head[1] & out_valid;
  assign out_memwr = head[0] & out_valid;

`ifdef EXMEM_OVF_TRAP_EN
  logic ovf_q, ovf_d;

  // Set wins over a same-edge clear.
  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr)           ovf_d = 1'b0;
    if (push && trap_cond) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign ovf_exc = ovf_q;
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = ovf_clr;
  assign ovf_exc        = 1'b0;
`endif

endmodule
